switch_debouncer: RTL and testbench

Input-conditioning block for the 60-second timer. It sits between the raw board switches and the counter chain. Each switch input is synchronized to `CLOCK_50` and debounced by an independent per-channel state machine. The block outputs clean levels plus single-cycle rise/fall pulses, which downstream logic uses as Reset/Direction/Hold controls and for edge-triggered commands.

---
 rtl/switch_debouncer_pkg.sv | 14 +
 rtl/switch_debouncer_if.sv | 12 +
 rtl/debounce_channel.sv | 113 +++++++++++
 rtl/switch_debouncer.sv | 37 +++
 tb/tb_switch_debouncer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared types and constants for the switch debouncer slice.
package switch_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } db_state_t;

    localparam int DB_CYCLES_50MHZ_10MS = 500000;
    localparam int DB_SYNC_STAGES       = 2;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bundle: raw levels in, clean levels and edge pulses out.
interface switch_debouncer_if #(
    parameter int N_SW = 3
);
    logic [N_SW-1:0] SW;
    logic [N_SW-1:0] SW_clean;
    logic [N_SW-1:0] SW_rise;
    logic [N_SW-1:0] SW_fall;

    modport master (output SW, input SW_clean, input SW_rise, input SW_fall);
    modport slave  (input SW, output SW_clean, output SW_rise, output SW_fall);
endinterface

// File: rtl/debounce_channel.sv
// One switch bit: 2-flop synchronizer, debounce FSM and hold counter.
// Edge pulse registers exist only when SW_EDGE_PULSE_EN is defined.
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_50MHZ_10MS,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_SYNC_STAGES:1] sync_pipe;
    logic                    s2;

    db_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            clean_q, clean_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[DB_SYNC_STAGES-1:1], sw};
    end

    assign s2 = sync_pipe[DB_SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    // Counter is compared for equality only; it is parked at 0 outside WAIT_*.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        unique case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (s2) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (!s2) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (s2) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign clean = clean_q;

`ifdef SW_EDGE_PULSE_EN
    logic rise_q, fall_q;

    // Pulses register the same edge that updates clean, so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= clean_d & ~clean_q;
            fall_q <= ~clean_d & clean_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Top: N_SW independent debounce channels. Edge pulses are built only
// when SW_EDGE_PULSE_EN is defined; otherwise SW_rise/SW_fall read 0.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int N_SW            = 3,
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_50MHZ_10MS,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               CLOCK_50,
    input  logic               Reset_n,
    switch_debouncer_if.slave  sw_if
);

    logic [N_SW-1:0] clean_w;
    logic [N_SW-1:0] rise_w;
    logic [N_SW-1:0] fall_w;

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (CLOCK_50),
            .rst_n (Reset_n),
            .sw    (sw_if.SW[i]),
            .clean (clean_w[i]),
            .rise  (rise_w[i]),
            .fall  (fall_w[i])
        );
    end

    assign sw_if.SW_clean = clean_w;
    assign sw_if.SW_rise  = rise_w;
    assign sw_if.SW_fall  = fall_w;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with DEBOUNCE_CYCLES=8: directed timing checks
// plus randomized switch activity against a run-length reference model.
module tb_switch_debouncer;

    localparam int N = 3;
    localparam int D = 8;

`ifdef SW_EDGE_PULSE_EN
    localparam logic [N-1:0] PMASK = '1;
`else
    localparam logic [N-1:0] PMASK = '0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    switch_debouncer_if #(.N_SW(N)) sw_if ();

    switch_debouncer #(
        .N_SW            (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLOCK_50 (clk),
        .Reset_n  (rst_n),
        .sw_if    (sw_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference: clean flips once the synchronized level has disagreed with it
    // on D+1 consecutive edges (edge 2 .. edge D+2 after the raw change).
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_fall = '0;
    int           run [N];

    initial begin
        for (int i = 0; i < N; i++) run[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
                for (int i = 0; i < N; i++) run[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    m_rise[i] = 1'b0;
                    m_fall[i] = 1'b0;
                    if (m_s2[i] != m_clean[i]) begin
                        run[i] = run[i] + 1;
                        if (run[i] == D + 1) begin
                            m_clean[i] = m_s2[i];
                            m_rise[i]  = m_s2[i];
                            m_fall[i]  = ~m_s2[i];
                            run[i]     = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
                m_s2 = m_s1;
                m_s1 = sw_if.SW;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_tests++;
                if ({sw_if.SW_clean, sw_if.SW_rise, sw_if.SW_fall} !==
                    {m_clean, m_rise & PMASK, m_fall & PMASK}) begin
                    n_fail++;
                    $display("FAIL model t=%0t: clean/rise/fall got %b/%b/%b expected %b/%b/%b",
                             $time, sw_if.SW_clean, sw_if.SW_rise, sw_if.SW_fall,
                             m_clean, m_rise & PMASK, m_fall & PMASK);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        sw_if.SW = '0;
        @(negedge clk);
        chk_en   = 1;

        // Reset held with switches high, then full upward debounce.
        sw_if.SW = 3'b111;
        cyc(3);
        chk("rst_clean", sw_if.SW_clean, 3'b000);
        chk("rst_rise",  sw_if.SW_rise,  3'b000);
        chk("rst_fall",  sw_if.SW_fall,  3'b000);
        rst_n = 1'b1;
        cyc(10);
        chk("rel_e9_clean", sw_if.SW_clean, 3'b000);
        cyc(1);
        chk("rel_e10_clean", sw_if.SW_clean, 3'b111);
        chk("rel_e10_rise",  sw_if.SW_rise,  3'b111 & PMASK);
        cyc(1);
        chk("rel_e11_rise",  sw_if.SW_rise,  3'b000);

        // Clean fall on channel 2.
        sw_if.SW = 3'b011;
        cyc(10);
        chk("fall_e9_clean", sw_if.SW_clean, 3'b111);
        cyc(1);
        chk("fall_e10_clean", sw_if.SW_clean, 3'b011);
        chk("fall_e10_fall",  sw_if.SW_fall,  3'b100 & PMASK);
        chk("fall_e10_rise",  sw_if.SW_rise,  3'b000);
        cyc(1);
        chk("fall_e11_fall",  sw_if.SW_fall,  3'b000);

        sw_if.SW = 3'b000;
        cyc(15);

        // Short glitch on channel 0.
        sw_if.SW = 3'b001;
        cyc(5);
        sw_if.SW = 3'b000;
        cyc(20);
        chk("glitch_clean", sw_if.SW_clean, 3'b000);

        // Bounce on channel 1, then settle high.
        for (int t = 0; t < 4; t++) begin
            sw_if.SW = (t % 2 == 0) ? 3'b010 : 3'b000;
            cyc(3);
        end
        sw_if.SW = 3'b010;
        cyc(10);
        chk("bounce_e9_clean", sw_if.SW_clean, 3'b000);
        cyc(1);
        chk("bounce_e10_clean", sw_if.SW_clean, 3'b010);
        chk("bounce_e10_rise",  sw_if.SW_rise,  3'b010 & PMASK);

        // Reset 4 cycles into WAIT_HI on channel 0; clean[1] is high beforehand.
        sw_if.SW = 3'b011;
        cyc(7);
        #1 rst_n = 1'b0;
        #1;
        chk("midwait_clean", sw_if.SW_clean, 3'b000);
        chk("midwait_rise",  sw_if.SW_rise,  3'b000);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        chk("midwait_e9_clean", sw_if.SW_clean, 3'b000);
        cyc(1);
        chk("midwait_e10_clean", sw_if.SW_clean, 3'b011);
        chk("midwait_e10_rise",  sw_if.SW_rise,  3'b011 & PMASK);

        // Simultaneous rise on channels 0 and 2.
        sw_if.SW = 3'b000;
        cyc(15);
        sw_if.SW = 3'b101;
        cyc(10);
        chk("simul_e9_clean", sw_if.SW_clean, 3'b000);
        cyc(1);
        chk("simul_e10_clean", sw_if.SW_clean, 3'b101);
        chk("simul_e10_rise",  sw_if.SW_rise,  3'b101 & PMASK);
        chk("simul_e10_fall",  sw_if.SW_fall,  3'b000);

        // Random activity with occasional asynchronous resets.
        for (int k = 0; k < 200; k++) begin
            sw_if.SW = sw_if.SW ^ N'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) begin
                #3 rst_n = 1'b0;
                cyc($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            cyc($urandom_range(1, 14));
        end
        sw_if.SW = 3'b000;
        cyc(15);
        chk("final_clean", sw_if.SW_clean, 3'b000);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
